// File: rtl/mxn_elastic_pipeline_pkg.sv
// Shared helpers for the elastic pipeline: occupancy counter sizing and
// lane slicing of the packed per-lane buses.
package pipeline_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mxn_elastic_pipeline_stage.sv
// One valid/data register stage. An empty stage always accepts, which is
// what lets upstream items collapse into holes behind a stalled output.
module elastic_stage #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             up_ready
);

    assign up_ready = ~valid | dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (clr)
                valid <= 1'b0;
            else if (up_ready)
                valid <= up_valid;
            // data of an empty stage is left stale on purpose
            if (up_ready && up_valid && !clr)
                data <= up_data;
        end
    end

endmodule

// File: rtl/mxn_elastic_pipeline.sv
// CHANNELS independent DEPTH-stage elastic lanes with per-lane flush and a
// registered occupancy count per lane.
module mxn_elastic_pipeline
    import pipeline_pkg::*;
#(
    parameter  int WIDTH    = 3,
    parameter  int DEPTH    = 4,
    parameter  int CHANNELS = 2,
    localparam int CW       = cnt_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       flush,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS*CW-1:0]    count
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [DEPTH:0]   r;
        logic [DEPTH-1:0] v;
        logic [WIDTH-1:0] d [DEPTH];
        logic [CW-1:0]    cnt;
        logic             push;
        logic             pop;

        // ready ripples from the consumer back to the input, DEPTH deep
        assign r[DEPTH] = out_ready[c];

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             uv;
            logic [WIDTH-1:0] ud;

            if (k == 0) begin : g_src
                assign uv = in_valid[c] & ~flush[c];
                assign ud = in_data[lane_lo(c, WIDTH) +: WIDTH];
            end else begin : g_chain
                assign uv = v[k-1];
                assign ud = d[k-1];
            end

            elastic_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (flush[c]),
                .up_valid (uv),
                .up_data  (ud),
                .dn_ready (r[k+1]),
                .valid    (v[k]),
                .data     (d[k]),
                .up_ready (r[k])
            );
        end

        assign in_ready[c]                         = r[0] & ~flush[c];
        assign out_valid[c]                        = v[DEPTH-1];
        assign out_data[lane_lo(c, WIDTH) +: WIDTH] = d[DEPTH-1];
        assign count[lane_lo(c, CW) +: CW]         = cnt;

        assign push = in_valid[c] & in_ready[c];
        assign pop  = v[DEPTH-1] & out_ready[c];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (flush[c])
                cnt <= '0;
            else
                cnt <= cnt + CW'(push) - CW'(pop);
        end

        a_count_matches_valids: assert property (
            @(posedge clk) disable iff (!rst_n) cnt == CW'($countones(v))
        );
    end

endmodule

// File: tb/tb_mxn_elastic_pipeline.sv
// Directed plus randomized bench for mxn_elastic_pipeline against a per-lane
// FIFO model with earliest-departure times.
module tb_mxn_elastic_pipeline;

    localparam int W  = 3;
    localparam int D  = 4;
    localparam int CH = 2;
    localparam int CW = 3;
    localparam int RS = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     flush = '0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH-1:0]     in_ready;
    logic [CH*W-1:0]   in_data = '0;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready = '0;
    logic [CH*W-1:0]   out_data;
    logic [CH*CW-1:0]  count;

    always #5 clk = ~clk;

    mxn_elastic_pipeline #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int ec       = 0;

    // model: per-lane ring of items, each with the edge after which it may
    // be at the output; an item also cannot surface before its predecessor leaves
    logic [W-1:0] md  [CH][RS];
    int           mav [CH][RS];
    int           hd  [CH];
    int           nq  [CH];
    int           lpop[CH];
    logic         acc [CH];

    function automatic logic e_ov(int c);
        int a;
        if (nq[c] == 0) return 1'b0;
        a = mav[c][hd[c]];
        if (lpop[c] > a) a = lpop[c];
        return ec >= a;
    endfunction

    function automatic logic e_ir(int c);
        return !flush[c] && (nq[c] < D || out_ready[c]);
    endfunction

    task automatic chk(string tag, int c, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s lane%0d observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            nq[c] = 0; hd[c] = 0; lpop[c] = 0; acc[c] = 1'b0;
        end
    endtask

    task automatic step();
        logic pu[CH];
        logic po[CH];
        int   idx;
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            chk("in_ready", c, in_ready[c], e_ir(c));
            chk("out_valid", c, out_valid[c], e_ov(c));
            chk("count", c, count[c*CW +: CW], nq[c]);
            if (e_ov(c)) chk("out_data", c, out_data[c*W +: W], md[c][hd[c]]);
            pu[c] = in_valid[c] && e_ir(c);
            po[c] = e_ov(c) && out_ready[c];
        end
        @(posedge clk);
        ec++;
        for (int c = 0; c < CH; c++) begin
            acc[c] = pu[c];
            if (po[c]) begin
                hd[c] = (hd[c] + 1) % RS;
                nq[c]--;
                lpop[c] = ec;
            end
            if (flush[c]) begin
                nq[c] = 0;
            end else if (pu[c]) begin
                idx = (hd[c] + nq[c]) % RS;
                md[c][idx]  = in_data[c*W +: W];
                mav[c][idx] = ec + D - 1;
                nq[c]++;
            end
        end
        #1;
    endtask

    task automatic push_hold(int c, logic [W-1:0] val);
        in_valid[c] = 1'b1;
        in_data[c*W +: W] = val;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc[c]) break;
        end
        chk("push_accept_timeout", c, acc[c], 1);
        in_valid[c] = 1'b0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        #3;
        for (int c = 0; c < CH; c++) begin
            chk("rst_out_valid", c, out_valid[c], 0);
            chk("rst_count", c, count[c*CW +: CW], 0);
            chk("rst_out_data", c, out_data[c*W +: W], 0);
            chk("rst_in_ready", c, in_ready[c], 1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // lane 0 streams 5,6,7 unstalled
        out_ready = '1;
        push_hold(0, 3'd5);
        push_hold(0, 3'd6);
        push_hold(0, 3'd7);
        chk("peak_count", 0, count[0 +: CW], 3);
        steps(6);

        // lane 1 fills while stalled, 5th push held then drained in order
        out_ready[1] = 1'b0;
        for (int i = 1; i <= 4; i++) push_hold(1, W'(i));
        chk("full_count", 1, count[CW +: CW], 4);
        chk("full_in_ready", 1, in_ready[1], 0);
        in_valid[1] = 1'b1;
        in_data[W +: W] = 3'd5;
        steps(2);
        out_ready[1] = 1'b1;
        push_hold(1, 3'd5);
        steps(6);

        // full lane with simultaneous push and pop
        out_ready[1] = 1'b0;
        for (int i = 0; i < 4; i++) push_hold(1, W'(i + 2));
        out_ready[1] = 1'b1;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data[W +: W] = W'(i);
            step();
            chk("pass_count", 1, count[CW +: CW], 4);
            chk("pass_in_ready", 1, in_ready[1], 1);
        end
        in_valid[1] = 1'b0;
        steps(6);

        // bubble collapse behind a stalled output
        out_ready[0] = 1'b0;
        push_hold(0, 3'd3);
        steps(2);
        push_hold(0, 3'd4);
        steps(4);
        chk("bubble_count", 0, count[0 +: CW], 2);
        chk("bubble_head", 0, out_data[0 +: W], 3);
        out_ready[0] = 1'b1;
        steps(3);

        // flush lane 0 while lane 1 keeps streaming
        out_ready[0] = 1'b0;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[W +: W] = W'(i + 1);
            push_hold(0, W'(i + 5));
        end
        flush[0] = 1'b1;
        in_valid[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        in_valid[0] = 1'b0;
        chk("flush_count", 0, count[0 +: CW], 0);
        chk("flush_out_valid", 0, out_valid[0], 0);
        steps(3);
        in_valid[1] = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) begin
                in_valid[c]       = ($urandom_range(9) < 7);
                out_ready[c]      = ($urandom_range(9) < 6);
                flush[c]          = ($urandom_range(29) == 0);
                in_data[c*W +: W] = W'($urandom);
            end
            step();
        end
        flush = '0;

        // asynchronous reset mid-stream
        in_valid = '1;
        out_ready = 2'b10;
        steps(3);
        #3 rst_n = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) begin
            chk("arst_out_valid", c, out_valid[c], 0);
            chk("arst_count", c, count[c*CW +: CW], 0);
        end
        model_reset();
        in_valid = '0;
        out_ready = '1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_hold(0, 3'd2);
        chk("post_rst_count", 0, count[0 +: CW], 1);
        steps(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
